// File: rtl/decoder_pkg.sv
// ---------------------------------------------------------------------------
// decoder_pkg
// Shared definitions for the encoded link decoder and the encoder's bench model.
//   CODE_W / LINES  : symbol width and number of restored y-lines
//   dec_word_t      : one decoded y-line word (bit i is y_i)
//   fifo_state_t    : FIFO control states
//   decode_sym()    : zero-flag + one-hot expansion of a symbol
// ---------------------------------------------------------------------------
package decoder_pkg;

    localparam int CODE_W = 3;
    localparam int LINES  = 8;

    typedef logic [LINES-1:0] dec_word_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PART  = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_t;

    // A set zero-flag means no y-line was active at the source.
    function automatic dec_word_t decode_sym(input logic z, input logic [CODE_W-1:0] a);
        dec_word_t word;
        word = '0;
        if (!z) begin
            word = dec_word_t'(1) << a;
        end
        return word;
    endfunction

endpackage

// File: rtl/dec_fifo2.sv
// ---------------------------------------------------------------------------
// dec_fifo2
// DEPTH-entry FIFO for decoded words, with an EMPTY/PART/FULL control FSM.
// Ports:
//   clk, srst    : clock, synchronous active-high reset
//   push, push_data : write request (ignored while full) and its data
//   pop          : read request (ignored while empty)
//   head_data    : word at rd pointer (8'h00 while empty)
//   not_full     : push may fire
//   not_empty    : head is valid
//   busy         : at least one entry held
// Storage is not reset; only pointers, count and state are.
// ---------------------------------------------------------------------------
module dec_fifo2
    import decoder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      srst,
    input  logic      push,
    input  dec_word_t push_data,
    input  logic      pop,
    output dec_word_t head_data,
    output logic      not_full,
    output logic      not_empty,
    output logic      busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    dec_word_t   mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    fifo_state_t state_reg, state_next;

    logic push_ok;
    logic pop_ok;

    // Ready flags come from registered state only.
    assign not_full  = (state_reg != ST_FULL);
    assign not_empty = (state_reg != ST_EMPTY);
    assign busy      = (count_reg != '0);
    assign head_data = not_empty ? mem[rd_ptr_reg] : dec_word_t'(0);

    assign push_ok = push && not_full;
    assign pop_ok  = pop && not_empty;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        state_next  = state_reg;

        if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end

        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase

        case (state_reg)
            ST_EMPTY: begin
                if (push_ok) begin
                    state_next = ST_PART;
                end
            end
            ST_PART: begin
                if (push_ok && !pop_ok && (count_reg == CNT_W'(DEPTH - 1))) begin
                    state_next = ST_FULL;
                end else if (pop_ok && !push_ok && (count_reg == CNT_W'(1))) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop_ok) begin
                    state_next = ST_PART;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            state_reg  <= ST_EMPTY;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            state_reg  <= state_next;
        end
    end

    // Writes during reset are discarded so a put in the reset cycle leaves no trace.
    always_ff @(posedge clk) begin
        if (push_ok && !srst) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/enc_link_decoder.sv
// ---------------------------------------------------------------------------
// enc_link_decoder
// Receiving end of the encoded link: decodes 3-bit symbols (+ zero flag) into
// an 8-line one-hot word and buffers it in a DEPTH-entry FIFO.
// Ports:
//   CLK, RST_N          : clock; reset (synchronous, active-high)
//   put_a/put_z/put_par : symbol, zero flag, even parity over {put_z, put_a}
//   EN_put / RDY_put    : put strobe / put may fire (FIFO not full)
//   get_y / RDY_get     : head word / head valid
//   EN_get              : dequeue strobe
//   mv_decbusy          : FIFO holds at least one entry
//   mv_perr_cnt         : saturating count of parity-dropped symbols
// Build option: define DECODER_PARITY_EN to drop bad-parity symbols and count
// them; otherwise put_par is ignored and mv_perr_cnt reads 0.
// ---------------------------------------------------------------------------
module enc_link_decoder
    import decoder_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [CODE_W-1:0] put_a,
    input  logic              put_z,
    input  logic              put_par,
    input  logic              EN_put,
    output logic              RDY_put,
    output logic [LINES-1:0]  get_y,
    output logic              RDY_get,
    input  logic              EN_get,
    output logic              mv_decbusy,
    output logic [CNT_W-1:0]  mv_perr_cnt
);

    logic      put_fire;
    logic      wr_en;
    dec_word_t dec_word;
    dec_word_t head_word;

    assign put_fire = EN_put && RDY_put;
    assign dec_word = decode_sym(put_z, put_a);

`ifdef DECODER_PARITY_EN
    logic             par_err;
    logic [CNT_W-1:0] perr_cnt_reg, perr_cnt_next;

    // Nonzero means the received parity disagrees with {put_z, put_a}.
    assign par_err = put_par ^ put_z ^ (^put_a);
    assign wr_en   = put_fire && !par_err;

    always_comb begin
        perr_cnt_next = perr_cnt_reg;
        if (put_fire && par_err && (perr_cnt_reg != {CNT_W{1'b1}})) begin
            perr_cnt_next = perr_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_N) begin
            perr_cnt_reg <= '0;
        end else begin
            perr_cnt_reg <= perr_cnt_next;
        end
    end

    assign mv_perr_cnt = perr_cnt_reg;
`else
    logic unused_par;
    assign unused_par  = put_par;
    assign wr_en       = put_fire;
    assign mv_perr_cnt = '0;
`endif

    dec_fifo2 #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .srst      (RST_N),
        .push      (wr_en),
        .push_data (dec_word),
        .pop       (EN_get),
        .head_data (head_word),
        .not_full  (RDY_put),
        .not_empty (RDY_get),
        .busy      (mv_decbusy)
    );

    assign get_y = head_word;

endmodule
